// File: rtl/sat_accum_16bit_pkg.sv
// +----------------------------------------------------------------------------+
// | sat_accum_16bit_pkg                                                        |
// | Shared types and constants for the saturating frame accumulator.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package sat_accum_16bit_pkg;

    localparam int DATA_W = 16;

    localparam logic [DATA_W-1:0] SAT_POS = 16'h7FFF;
    localparam logic [DATA_W-1:0] SAT_NEG = 16'h8000;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sat_accum_16bit_addsub.sv
// +----------------------------------------------------------------------------+
// | addsub_16bit_cla                                                           |
// | 16-bit signed add/subtract, 4-bit-group carry lookahead, saturating.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module addsub_16bit_cla
    import sat_accum_16bit_pkg::*;
(
    output logic [DATA_W-1:0] Sum,
    output logic              Ovfl,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              Sub
);

    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_g;
    logic [DATA_W-1:0] w_p;
    logic [DATA_W-1:0] w_raw;
    logic              w_c15;
    logic              w_c16;
    logic              w_grp_c;
    logic              w_bit_c;
    logic              w_grp_g;
    logic              w_grp_p;

    assign w_b = B ^ {DATA_W{Sub}};
    assign w_g = A & w_b;
    assign w_p = A ^ w_b;

    // Group generate/propagate skip the carry across each nibble; bit carries ripple inside it.
    always_comb begin
        w_raw   = '0;
        w_c15   = 1'b0;
        w_grp_c = Sub;
        w_bit_c = 1'b0;
        w_grp_g = 1'b0;
        w_grp_p = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w_grp_g = w_g[4*k+3]
                    | (w_p[4*k+3] & w_g[4*k+2])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
            w_grp_p = &w_p[4*k +: 4];
            w_bit_c = w_grp_c;
            for (int j = 0; j < 4; j++) begin
                w_raw[4*k+j] = w_p[4*k+j] ^ w_bit_c;
                if (4*k+j == DATA_W-1) begin
                    w_c15 = w_bit_c;
                end
                w_bit_c = w_g[4*k+j] | (w_p[4*k+j] & w_bit_c);
            end
            w_grp_c = w_grp_g | (w_grp_p & w_grp_c);
        end
        w_c16 = w_grp_c;
    end

    // On overflow the true result's sign equals A's sign (operands had matching signs).
    assign Ovfl = w_c16 ^ w_c15;
    assign Sum  = Ovfl ? (A[DATA_W-1] ? SAT_NEG : SAT_POS) : w_raw;

endmodule

`default_nettype wire

// File: rtl/sat_accum_16bit.sv
// +----------------------------------------------------------------------------+
// | sat_accum_16bit                                                            |
// | Frame-based saturating accumulator with valid/ready in and out.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module sat_accum_16bit
    import sat_accum_16bit_pkg::*;
#(
    parameter int N_ITEMS = 4
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sub,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_ovfl
);

    localparam int CNT_W = ($clog2(N_ITEMS + 1) > 1) ? $clog2(N_ITEMS + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_ITEMS - 1);

    state_t             state;
    state_t             state_next;
    logic [DATA_W-1:0]  acc;
    logic [CNT_W-1:0]   cnt;
    logic               sticky;
    logic [DATA_W-1:0]  add_sum;
    logic               add_ovfl;
    logic               accept;
    logic               last;

    addsub_16bit_cla u_addsub (
        .Sum  (add_sum),
        .Ovfl (add_ovfl),
        .A    (acc),
        .B    (in_data),
        .Sub  (in_sub)
    );

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign out_sum   = acc;
    assign out_ovfl  = sticky;

    assign accept = in_valid && in_ready && !abort;
    assign last   = (cnt == LAST_CNT);

    always_comb begin
        state_next = state;
        case (state)
            ACCUM: if (accept && last) state_next = HOLD;
            HOLD:  if (out_ready)      state_next = ACCUM;
            default:                   state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Abort only matters in ACCUM; a held result is never discarded.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
        end else if (state == ACCUM) begin
            if (abort) begin
                acc    <= '0;
                cnt    <= '0;
                sticky <= 1'b0;
            end else if (accept) begin
                acc    <= add_sum;
                sticky <= sticky | add_ovfl;
                cnt    <= last ? '0 : cnt + 1'b1;
            end
        end else if (out_ready) begin
            acc    <= '0;
            sticky <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sat_accum_16bit.sv
// +----------------------------------------------------------------------------+
// | tb_sat_accum_16bit                                                         |
// | Directed self-checking bench for the saturating frame accumulator.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sat_accum_16bit;
    import sat_accum_16bit_pkg::*;

    logic              clock;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_sub;
    logic              abort;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_sum;
    logic              out_ovfl;

    int n_checks = 0;
    int n_fail   = 0;

    sat_accum_16bit #(.N_ITEMS(4)) dut (
        .clock     (clock),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sub    (in_sub),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovfl  (out_ovfl)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic item(input logic [15:0] data, input logic sub);
        in_valid = 1'b1;
        in_data  = data;
        in_sub   = sub;
        step();
        in_valid = 1'b0;
    endtask

    task automatic frame4(input logic [15:0] d0, input logic [15:0] d1,
                          input logic [15:0] d2, input logic [15:0] d3);
        item(d0, 1'b0);
        item(d1, 1'b0);
        item(d2, 1'b0);
        item(d3, 1'b0);
    endtask

    task automatic check_hold(input string tag, input logic [15:0] sum, input logic ovfl);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_ready"}, {31'd0, in_ready},  32'd0);
        check({tag, "_sum"},   {16'd0, out_sum},   {16'd0, sum});
        check({tag, "_ovfl"},  {31'd0, out_ovfl},  {31'd0, ovfl});
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_ready"}, {31'd0, in_ready},  32'd1);
        check({tag, "_sum"},   {16'd0, out_sum},   32'd0);
        check({tag, "_ovfl"},  {31'd0, out_ovfl},  32'd0);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sub    = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        check_idle("reset");
        rst = 1'b0;
        step();

        // Basic add: 1+2+3+4
        item(16'd1, 1'b0);
        item(16'd2, 1'b0);
        item(16'd3, 1'b0);
        check({"basic_pre_valid"}, {31'd0, out_valid}, 32'd0);
        item(16'd4, 1'b0);
        check_hold("basic", 16'h000A, 1'b0);
        release_result();
        check_idle("basic_rel");

        // Positive saturation then recovery
        frame4(16'h7000, 16'h7000, 16'hFFFF, 16'h0000);
        check_hold("satpos", 16'h7FFE, 1'b1);
        release_result();
        check_idle("satpos_rel");

        // Subtraction path: 10 - 3 - 20 + 1 = -12
        item(16'd10, 1'b0);
        item(16'd3,  1'b1);
        item(16'd20, 1'b1);
        item(16'd1,  1'b0);
        check_hold("sub", 16'hFFF4, 1'b0);
        release_result();

        // 0 - (-32768) saturates positive
        item(16'h8000, 1'b1);
        item(16'h0000, 1'b0);
        item(16'h0000, 1'b0);
        item(16'h0000, 1'b0);
        check_hold("subsat", SAT_POS, 1'b1);
        release_result();

        // Negative saturation, then backpressure with in_valid held high
        frame4(16'h8000, 16'hFFFF, 16'h0000, 16'h0000);
        check_hold("satneg", SAT_NEG, 1'b1);
        in_valid = 1'b1;
        in_data  = 16'h0100;
        for (int i = 0; i < 5; i++) begin
            step();
            check_hold("bp", SAT_NEG, 1'b1);
        end
        in_valid = 1'b0;
        release_result();
        check_idle("bp_rel");
        frame4(16'd5, 16'd5, 16'd5, 16'd5);
        check_hold("after_bp", 16'h0014, 1'b0);
        release_result();

        // Abort drops the colliding item and the partial frame
        item(16'd3, 1'b0);
        item(16'd7, 1'b0);
        abort = 1'b1;
        item(16'd9, 1'b0);
        abort = 1'b0;
        check({"abort_valid"}, {31'd0, out_valid}, 32'd0);
        check({"abort_sum"},   {16'd0, out_sum},   32'd0);
        frame4(16'd1, 16'd1, 16'd1, 16'd1);
        check_hold("abort_frame", 16'h0004, 1'b0);

        // Abort in HOLD is ignored
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_hold("abort_hold", 16'h0004, 1'b0);
        release_result();

        // Abort after saturation clears the sticky flag
        item(16'h7000, 1'b0);
        item(16'h7000, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        frame4(16'd1, 16'd1, 16'd1, 16'd1);
        check_hold("abort_sticky", 16'h0004, 1'b0);

        // Asynchronous reset while holding
        #3;
        rst = 1'b1;
        #1;
        check_idle("rst_hold");
        #2;
        rst = 1'b0;
        step();

        // Asynchronous reset mid-frame
        item(16'd5, 1'b0);
        item(16'h7000, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check_idle("rst_mid");
        #2;
        rst = 1'b0;
        step();
        frame4(16'd2, 16'd2, 16'd2, 16'd2);
        check_hold("post_rst", 16'h0008, 1'b0);
        release_result();
        check_idle("final");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sat_accum_16bit.md
# sat_accum_16bit

Frame-based saturating accumulator that sits directly downstream of `addsub_16bit_cla` and feeds it. It holds a 16-bit running sum as the adder's A operand and takes the B operand and Sub control from an input stream. It registers the adder's saturated Sum and Ovfl back into the sum each accepted item. After `N_ITEMS` items it presents the frame result on a valid/ready output port. It is the reduction stage for the datapath's accumulate operations.

## Interface
- `N_ITEMS`, default 4: items per frame; legal range 1..65535.
- `clock` input 1: single clock; all state updates on posedge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: an input item is present.
- `in_ready` output 1: the block can accept an item this cycle.
- `in_data` input 16: signed two's-complement operand, used as adder B.
- `in_sub` input 1: 1 means acc − in_data; 0 means acc + in_data.
- `abort` input 1: synchronous; discards the frame in progress.
- `out_valid` output 1: a frame result is held.
- `out_ready` input 1: the consumer takes the result.
- `out_sum` output 16: saturated frame sum.
- `out_ovfl` output 1: sticky flag; at least one step of the frame saturated.

## Operation
- Two states:
  - ACCUM: `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- Reset (asynchronous, takes effect immediately, including mid-frame or in HOLD):
  - state=ACCUM, acc=0x0000, cnt=0, sticky=0.
  - Outputs: `out_valid`=0, `in_ready`=1, `out_sum`=0x0000, `out_ovfl`=0.
- Accept rule: an item is accepted on a posedge where `in_valid` && `in_ready` && !`abort`. On accept:
  - acc ← Sum of the adder, with A=acc, B=`in_data`, Sub=`in_sub`.
  - sticky ← sticky | Ovfl.
  - cnt ← cnt+1.
- Arithmetic rules:
  - True signed result is A±B over 17 bits.
  - If the result is above 32767, Sum=0x7FFF and Ovfl=1.
  - If the result is below −32768, Sum=0x8000 and Ovfl=1.
  - Otherwise Sum is the exact result and Ovfl=0.
  - Saturation applies per step. A saturated acc is not frozen: later items move it normally.
- Frame end: the accept that brings cnt to `N_ITEMS` moves ACCUM→HOLD.
  - acc and sticky now hold the final values.
  - cnt resets to 0.
- HOLD:
  - `out_sum`=acc and `out_ovfl`=sticky, both driven directly from registers.
  - Both stay stable while `out_valid`=1 and `out_ready`=0.
  - On `out_ready`=1: HOLD→ACCUM, acc←0, sticky←0.
- Abort:
  - In ACCUM: acc←0, cnt←0, sticky←0; state remains ACCUM. Abort beats a simultaneous accept; that item is dropped.
  - In HOLD: ignored. A held result is never discarded.
- `in_data` and `in_sub` are don't-care when no item is accepted.

## Timing
- The adder path is combinational. It is acc register → adder → acc register, one cycle per item.
- Result latency: `out_valid` rises on the posedge of the last accept. The result is visible the cycle after that item is presented.
- `in_ready` falls on that same edge. No item is accepted while `out_valid`=1.
- Result release: the posedge with `out_valid`=1 and `out_ready`=1 consumes the result. On the next cycle `in_ready`=1 and acc=0.
- Throughput with `out_ready` held high: one frame per `N_ITEMS`+1 cycles.
- Counter width is max(1, $clog2(`N_ITEMS`+1)). With `N_ITEMS`=1, every accept goes straight to HOLD.

## Structure
- Shared package contains:
  - State enum {ACCUM, HOLD}.
  - SAT_POS=16'h7FFF, SAT_NEG=16'h8000, used by the bench reference model.
  - DATA_W=16.
- One sub-module: `addsub_16bit_cla`, instantiated unmodified.
  - Port order is (Sum, Ovfl, A, B, Sub).
  - A=acc, B=`in_data`, Sub=`in_sub`.
- All else is in one module: FSM, counter, acc and sticky registers.

## Test plan
- Reset: assert `rst` asynchronously. Outputs go immediately to `out_valid`=0, `in_ready`=1, `out_sum`=0x0000, `out_ovfl`=0.
- Basic add (`N_ITEMS`=4): items +1, +2, +3, +4, back to back. `out_valid`=1 on the cycle after the 4th item, `out_sum`=0x000A, `out_ovfl`=0.
- Saturation and recovery: items +0x7000, +0x7000, −0x0001, +0x0000.
  - acc sequence is 0x7000, 0x7FFF, 0x7FFE, 0x7FFE.
  - Final `out_sum`=0x7FFE, `out_ovfl`=1.
  - Negative case: −0x8000 then −0x0001 gives 0x8000 with the flag set.
- Backpressure: hold `out_ready`=0 for 5 cycles with `in_valid`=1.
  - `in_ready`=0 throughout; `out_sum` and `out_ovfl` stay unchanged.
  - After `out_ready` pulses, the next frame +5 ×4 yields 0x0014.
- Abort:
  - Accept +3 and +7, then assert `abort` together with `in_valid` (+9). That item is dropped and acc=0.
  - Then +1 ×4 yields 0x0004, `out_ovfl`=0.
  - `abort` during HOLD leaves the result unchanged.
- Reset during HOLD and mid-frame: `out_valid` clears immediately.
  - The first frame after reset, +2 ×4, yields 0x0008.
  - No residue from the interrupted frame remains.
